spi_pwm_bank: RTL and testbench
===============================

# spi_pwm_bank

Parametrised SPI-controlled PWM bank: the next-generation peripheral of the onboarding design, generalising the fixed 16-output, single-duty, write-only SPI/PWM pair. It adds a configurable channel count, a per-channel duty register, SPI read-back, frame-error detection and glitch-free, period-aligned duty updates. It sits directly behind the top-level pins: SPI from dedicated inputs, PWM bus to dedicated/bidirectional outputs.

## Interface
- CHANNELS, 16, number of PWM outputs; multiple of 8, range 8..32
- STEP_DIV, 10, clk cycles per PWM step (>=1); PWM period = 256*STEP_DIV cycles
- SYNC_STAGES, 2, synchroniser depth on sclk/copi/cs_n (>=2)

- clk  in  1  system clock; the only clock
- rst  in  1  asynchronous, active-high reset
- sclk  in  1  SPI clock, mode 0, asynchronous to clk; sclk <= clk/8
- copi  in  1  SPI data in, MSB first
- cs_n  in  1  SPI chip select, active low
- cipo  out  1  SPI read data
- cipo_oe  out  1  high while a frame is active (synchronised cs_n low)
- pwm_out  out  CHANNELS  channel outputs
- frame_err  out  1  one-cycle pulse on aborted frame

## Operation
- sclk, copi, cs_n pass through SYNC_STAGES flops, then one edge-detect flop; all logic uses synchronised signals.
- Frame = 16 bits: bit15 R/W (1 = write), bits14:8 address, bits7:0 data. copi sampled on sclk rising edge.
- Synchronised cs_n falling: bit counter cleared, shift register cleared, cipo_oe=1.
- Write: committed on synchronised cs_n rising only if exactly 16 bits received.
- Read (bit15=0): after the 8th rising edge, addressed register latched into the output shifter; its MSB drives cipo immediately; each following sclk falling edge shifts out the next bit. cipo=0 outside the data phase and whenever cipo_oe=0.
- Any cs_n rise with bit count != 16: no write, frame_err pulses 1 cycle. Bits beyond 16 count as error (counter saturates at 17).
- Register map (N8 = CHANNELS/8):
  - 0x00..0x00+N8-1: out_en bytes (byte k = channels 8k+7..8k)
  - 0x10..0x10+N8-1: pwm_en bytes
  - 0x20..0x20+CHANNELS-1: duty, one byte per channel
  - Other addresses: writes ignored, reads return 0x00, no frame_err.
- PWM: 8-bit step counter 0..255, advancing every STEP_DIV cycles, wrapping 255->0 (period start).
- Each channel has duty_reg (SPI-visible) and duty_act (shadow); duty_act <= duty_reg at every period start. Reads return duty_reg.
- Channel output: out_en=0 -> 0; out_en=1, pwm_en=0 -> 1; both 1 -> (duty_act==0xFF) ? 1 : (count < duty_act). duty 0x00 -> constant 0.
- pwm_out is registered.

## Timing
- Reset: all registers, duty_act, counters, shifters = 0; pwm_out=0, cipo=0, cipo_oe=0, frame_err=0. Reset mid-frame discards the frame; frame resumes only after a new cs_n fall.
- Pin-to-sync latency: SYNC_STAGES+1 cycles for every SPI edge.
- Write latency: register updated on the cycle after the synchronised cs_n rise is detected; out_en/pwm_en changes reach pwm_out one cycle later.
- Duty write: takes effect at the next period start, never mid-period; a write landing on the wrap cycle takes effect at the following period start.
- Step/prescaler counters free-run; SPI activity never resets them.
- cs_n rise and fall within one clk after sync: treated as separate events in order; no write without 16 bits.

## Test plan
- Reset release -> pwm_out=0, cipo_oe=0; write 0x00=0xFF, 0x01=0x0F (CHANNELS=16) -> pwm_out=0x0FFF constant high within 2 cycles of synchronised cs_n rise.
- Write pwm_en 0x10=0x01, duty 0x20=0x80 -> channel 0 high exactly 128*STEP_DIV cycles per 2560-cycle period, first changed period begins at next wrap.
- Duty 0x00 -> channel constantly 0; duty 0xFF -> constantly 1; mid-period write of 0x40 -> current period unchanged, next period 64 steps high.
- Read frame address 0x20 after writing 0xA5 -> cipo shifts 1,0,1,0,0,1,0,1 on data-phase bits; read of 0x7F -> 0x00.
- 12-bit frame writing 0x00 -> register unchanged, frame_err one-cycle pulse; 17-bit frame -> same.
- Assert rst mid-frame (after 10 bits) -> all outputs 0 immediately; next full frame after release writes correctly.

Source files
------------

// File: rtl/spi_pwm_bank.sv
// SPI-controlled PWM bank: synchronised SPI slave with read-back and frame-error
// detection, per-channel enables and duty registers, period-aligned duty shadowing.
module spi_pwm_bank #(
    parameter int unsigned CHANNELS    = 16,
    parameter int unsigned STEP_DIV    = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk,
    input  logic                copi,
    input  logic                cs_n,
    output logic                cipo,
    output logic                cipo_oe,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                frame_err
);

    localparam int unsigned N8 = CHANNELS / 8;
    localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    typedef enum logic {FR_IDLE, FR_ACTIVE} frame_state_t;

    frame_state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sr, copi_sr, cs_sr;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, copi_s, cs_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [4:0]  bit_cnt;
    logic [15:0] shift;
    logic [7:0]  rd_shift;
    logic [6:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        frame_end, wr_en;

    logic [CHANNELS-1:0] out_en, pwm_en;
    logic [7:0]          duty_reg [CHANNELS];
    logic [7:0]          duty_act [CHANNELS];

    logic [PW-1:0]       presc;
    logic [7:0]          step;
    logic                step_tick, period_start;
    logic [CHANNELS-1:0] pwm_next;

    assign sclk_s    = sclk_sr[SYNC_STAGES-1];
    assign copi_s    = copi_sr[SYNC_STAGES-1];
    assign cs_s      = cs_sr[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    // Sync chains reset low: the idle-high cs_n after reset shows up as a rise
    // while idle and is ignored, so a frame only starts on a real cs_n fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sr <= '0;
            copi_sr <= '0;
            cs_sr   <= '0;
            sclk_d  <= 1'b0;
            cs_d    <= 1'b0;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
            copi_sr <= {copi_sr[SYNC_STAGES-2:0], copi};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs_n};
            sclk_d  <= sclk_s;
            cs_d    <= cs_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FR_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FR_IDLE:   if (cs_fall) state_next = FR_ACTIVE;
            FR_ACTIVE: if (cs_rise) state_next = FR_IDLE;
            default:   state_next = FR_IDLE;
        endcase
    end

    always_comb begin
        cipo_oe = (state == FR_ACTIVE);
        cipo    = (state == FR_ACTIVE) & rd_shift[7];
    end

    assign frame_end = (state == FR_ACTIVE) && cs_rise;
    assign wr_en     = frame_end && (bit_cnt == 5'd16) && shift[15];
    assign rd_addr   = {shift[5:0], copi_s};

    // On the 8th rising edge shift[6] holds the R/W bit and copi_s the last address bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift     <= '0;
            rd_shift  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_end && (bit_cnt != 5'd16);
            if (cs_fall) begin
                bit_cnt  <= '0;
                shift    <= '0;
                rd_shift <= '0;
            end else if (state == FR_ACTIVE) begin
                if (sclk_rise) begin
                    if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt < 5'd16) shift <= {shift[14:0], copi_s};
                    if ((bit_cnt == 5'd7) && !shift[6]) rd_shift <= rd_data;
                end else if (sclk_fall) begin
                    rd_shift <= {rd_shift[6:0], 1'b0};
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < N8; k++) begin
            if (rd_addr == 7'(k))      rd_data = out_en[8*k +: 8];
            if (rd_addr == 7'(16 + k)) rd_data = pwm_en[8*k +: 8];
        end
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (rd_addr == 7'(32 + c)) rd_data = duty_reg[c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_en <= '0;
            pwm_en <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) duty_reg[c] <= '0;
        end else if (wr_en) begin
            for (int unsigned k = 0; k < N8; k++) begin
                if (shift[14:8] == 7'(k))      out_en[8*k +: 8] <= shift[7:0];
                if (shift[14:8] == 7'(16 + k)) pwm_en[8*k +: 8] <= shift[7:0];
            end
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (shift[14:8] == 7'(32 + c)) duty_reg[c] <= shift[7:0];
            end
        end
    end

    assign step_tick    = (presc == PW'(STEP_DIV - 1));
    assign period_start = step_tick && (step == 8'hFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            step  <= '0;
        end else if (step_tick) begin
            presc <= '0;
            step  <= step + 8'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // A register write on the wrap edge is not seen here until the next wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < CHANNELS; c++) duty_act[c] <= '0;
        end else if (period_start) begin
            for (int unsigned c = 0; c < CHANNELS; c++) duty_act[c] <= duty_reg[c];
        end
    end

    always_comb begin
        pwm_next = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            pwm_next[c] = out_en[c] & (~pwm_en[c] | (duty_act[c] == 8'hFF) | (step < duty_act[c]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= pwm_next;
        end
    end

endmodule

// File: tb/tb_spi_pwm_bank.sv
// Bench for spi_pwm_bank: directed and random SPI frames, cycle-exact PWM reference
// model derived from the edge count since reset, read-back and frame-error checks.
module tb_spi_pwm_bank;

    localparam int unsigned CH = 16;
    localparam int unsigned SD = 10;
    localparam int unsigned SS = 2;
    localparam int unsigned P  = 256 * SD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sclk = 1'b0;
    logic          copi = 1'b0;
    logic          cs_n = 1'b1;
    logic          cipo, cipo_oe, frame_err;
    logic [CH-1:0] pwm_out;

    spi_pwm_bank #(.CHANNELS(CH), .STEP_DIV(SD), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .cs_n(cs_n),
        .cipo(cipo), .cipo_oe(cipo_oe), .pwm_out(pwm_out), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model state
    typedef struct {
        int unsigned edge_no;
        logic [6:0]  addr;
        logic [7:0]  data;
    } wr_t;

    logic [CH-1:0] m_out_en, m_pwm_en;
    logic [7:0]    m_duty [CH];
    logic [7:0]    m_act  [CH];
    wr_t           pend [$];
    int unsigned   n_edges = 0;
    int unsigned   k_c, step_c;
    logic [CH-1:0] exp_pwm;
    int unsigned   err_pulses = 0, err_hi = 0, exp_err = 0;
    logic          err_prev = 1'b0;

    function automatic void m_apply(input int unsigned a, input logic [7:0] d);
        if (a < CH / 8) m_out_en[8*a +: 8] = d;
        else if (a >= 16 && a < 16 + CH / 8) m_pwm_en[8*(a-16) +: 8] = d;
        else if (a >= 32 && a < 32 + CH) m_duty[a-32] = d;
    endfunction

    function automatic logic [7:0] m_read(input int unsigned a);
        if (a < CH / 8) return m_out_en[8*a +: 8];
        if (a >= 16 && a < 16 + CH / 8) return m_pwm_en[8*(a-16) +: 8];
        if (a >= 32 && a < 32 + CH) return m_duty[a-32];
        return 8'h00;
    endfunction

    function automatic logic m_chan(input int unsigned c, input int unsigned s);
        if (!m_out_en[c]) return 1'b0;
        if (!m_pwm_en[c]) return 1'b1;
        if (m_act[c] == 8'hFF) return 1'b1;
        return (s < m_act[c]);
    endfunction

    initial forever begin
        @(posedge clk);
        n_edges = rst ? 0 : n_edges + 1;
    end

    // After edge k the output reflects step floor((k-1)/SD) mod 256 and the state held before edge k.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            m_out_en = '0;
            m_pwm_en = '0;
            for (int c = 0; c < CH; c++) begin
                m_duty[c] = '0;
                m_act[c]  = '0;
            end
            pend.delete();
        end else if (n_edges > 0) begin
            k_c    = n_edges;
            step_c = ((k_c - 1) / SD) % 256;
            for (int unsigned c = 0; c < CH; c++) exp_pwm[c] = m_chan(c, step_c);
            if (k_c % P == 0) begin
                for (int c = 0; c < CH; c++) m_act[c] = m_duty[c];
            end
            while (pend.size() > 0 && pend[0].edge_no <= k_c) begin
                m_apply(pend[0].addr, pend[0].data);
                void'(pend.pop_front());
            end
            check("pwm_out", pwm_out, exp_pwm);
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            err_prev = 1'b0;
        end else begin
            if (frame_err) err_hi++;
            if (frame_err && !err_prev) err_pulses++;
            err_prev = frame_err;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic spi_frame(input logic [15:0] word, input int unsigned nbits, output logic [7:0] rd);
        logic is_read;
        is_read = !word[15] && (nbits == 16);
        rd = '0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        check("cipo_oe_active", cipo_oe, 1);
        for (int unsigned i = 0; i < nbits; i++) begin
            copi = (i < 16) ? word[15-i] : 1'($urandom);
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            repeat (7) @(negedge clk);
            if (is_read && i >= 7 && i <= 14) rd[14-i] = cipo;
            else check("cipo_quiet", cipo, 0);
            @(negedge clk);
            sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        copi = 1'b0;
        cs_n = 1'b1;
        if (nbits == 16 && word[15]) pend.push_back('{n_edges + SS + 1, word[14:8], word[7:0]});
        if (nbits != 16) exp_err++;
        repeat (12) @(negedge clk);
        check("cipo_oe_idle", cipo_oe, 0);
        check("frame_err_pulses", err_pulses, exp_err);
        check("frame_err_width", err_hi, exp_err);
    endtask

    task automatic measure_period(output int unsigned hi);
        int unsigned guard;
        guard = 0;
        hi = 0;
        @(negedge clk);
        while ((n_edges % P) != 0 && guard < P + 4) begin
            @(negedge clk);
            guard++;
        end
        check("period_sync", 32'((n_edges % P) == 0), 1);
        for (int unsigned j = 0; j < P; j++) begin
            @(negedge clk);
            hi += 32'(pwm_out[0]);
        end
    endtask

    task automatic rest_of_period(input logic [7:0] duty, output int unsigned hi, output int unsigned exp_hi);
        int unsigned k;
        hi = 0;
        exp_hi = 0;
        k = 1;
        while ((k % P) != 0) begin
            @(negedge clk);
            k = n_edges;
            hi += 32'(pwm_out[0]);
            if ((((k - 1) / SD) % 256) < duty) exp_hi++;
        end
    endtask

    logic [7:0]  rd;
    int unsigned hi, exp_hi, pick;
    logic [6:0]  ra;
    logic [7:0]  rdat;

    initial begin
        repeat (4) @(negedge clk);
        check("rst_pwm", pwm_out, 0);
        check("rst_cipo", cipo, 0);
        check("rst_cipo_oe", cipo_oe, 0);
        check("rst_frame_err", frame_err, 0);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_pwm", pwm_out, 0);
        check("post_rst_cipo_oe", cipo_oe, 0);

        spi_frame(16'h80FF, 16, rd);
        spi_frame(16'h810F, 16, rd);
        check("out_en_const", pwm_out, 16'h0FFF);

        spi_frame(16'h9001, 16, rd);
        spi_frame(16'hA080, 16, rd);
        measure_period(hi);
        check("duty80_high", hi, 128 * SD);

        repeat (300) @(negedge clk);
        spi_frame(16'hA040, 16, rd);
        rest_of_period(8'h80, hi, exp_hi);
        check("duty_mid_unchanged", hi, exp_hi);
        measure_period(hi);
        check("duty40_high", hi, 64 * SD);

        spi_frame(16'hA000, 16, rd);
        measure_period(hi);
        measure_period(hi);
        check("duty00_high", hi, 0);
        spi_frame(16'hA0FF, 16, rd);
        measure_period(hi);
        measure_period(hi);
        check("dutyFF_high", hi, P);

        spi_frame(16'hA0A5, 16, rd);
        spi_frame(16'h2000, 16, rd);
        check("read_a5", rd, 8'hA5);
        spi_frame(16'h7F00, 16, rd);
        check("read_7f", rd, 8'h00);

        spi_frame(16'h8000, 12, rd);
        spi_frame(16'h0000, 16, rd);
        check("short_frame_kept", rd, 8'hFF);
        spi_frame(16'h8000, 17, rd);
        spi_frame(16'h0000, 16, rd);
        check("long_frame_kept", rd, 8'hFF);

        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(0, 23);
            if (pick < 16) ra = 7'(32 + pick);
            else begin
                case (pick)
                    16: ra = 7'h00;
                    17: ra = 7'h01;
                    18: ra = 7'h10;
                    19: ra = 7'h11;
                    20: ra = 7'h05;
                    21: ra = 7'h7F;
                    22: ra = 7'h30;
                    default: ra = 7'h12;
                endcase
            end
            rdat = 8'($urandom);
            if ($urandom_range(0, 9) < 6) begin
                spi_frame({1'b1, ra, rdat}, 16, rd);
            end else begin
                spi_frame({1'b0, ra, 8'h00}, 16, rd);
                check("rand_read", rd, m_read(ra));
            end
        end
        repeat (2 * P) @(negedge clk);

        spi_frame(16'h80FF, 16, rd);
        spi_frame(16'h9000, 16, rd);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            copi = 1'($urandom);
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
        #1 rst = 1'b1;
        #1;
        check("midrst_pwm", pwm_out, 0);
        check("midrst_cipo", cipo, 0);
        check("midrst_cipo_oe", cipo_oe, 0);
        check("midrst_frame_err", frame_err, 0);
        copi = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_oe_low", cipo_oe, 0);
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midrst_no_err", err_pulses, exp_err);
        spi_frame(16'h0000, 16, rd);
        check("midrst_reg_cleared", rd, 8'h00);
        spi_frame(16'hA13C, 16, rd);
        spi_frame(16'h2100, 16, rd);
        check("midrst_write_ok", rd, 8'h3C);
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
